imem_boot_loader: RTL

Boot-time controller that fills the instruction memory of the single-cycle RV32I core from a byte stream and holds the core in reset until the program is in place. It sits between a byte source (UART receiver or testbench) and the IMEM write port. It packs 4 bytes little-endian into one 32-bit instruction word, writes the words sequentially from address 0, then releases `core_reset`. It owns the IMEM write side only; the core's fetch path (`Instr_Addr` / `Instr_rdata`) is untouched.

---
 rtl/imem_boot_loader_if.sv | 34 +++
 rtl/imem_boot_loader.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader_if.sv
// Byte-stream / IMEM-write bundle for the boot loader.
//   rx_data    : program byte from the source
//   rx_valid   : rx_data valid, held by the source until accepted
//   rx_ready   : loader accepts a byte this cycle
//   imem_we    : IMEM write strobe, one cycle per word
//   imem_waddr : word-aligned byte address of the write
//   imem_wdata : assembled little-endian instruction word
// Modport slave is the loader's view, master is the byte source / IMEM side.
interface imem_boot_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output imem_we,
        output imem_waddr,
        output imem_wdata
    );

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  imem_we,
        input  imem_waddr,
        input  imem_wdata
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: packs a byte stream (LSB first) into 32-bit words, writes them
// to IMEM from address 0 upward and keeps the RV32I core in reset until the
// whole program is in place.
//   clk        : system clock, rising edge
//   reset      : synchronous active-high reset
//   start      : request a (re)load; honoured in IDLE, DONE and ERR only
//   word_count : number of words to load, latched on an accepted start
//   bus        : byte stream in, IMEM write port out (imem_boot_loader_if)
//   core_reset : core held in reset unless a load has completed
//   busy       : receiving or writing
//   done       : load complete
//   err        : requested count exceeded DEPTH
module imem_boot_loader #(
    parameter int DEPTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [$clog2(DEPTH):0]  word_count,
    imem_boot_loader_if.slave       bus,
    output logic                    core_reset,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] word_idx;
    logic [1:0]    byte_cnt;
    logic [23:0]   byte_buf;
    logic          accept;

    // Decision taken on an accepted start, identical from IDLE, DONE and ERR.
    function automatic state_t start_target(input logic [CW-1:0] wc);
        state_t tgt;
        if (wc == {CW{1'b0}}) begin
            tgt = ST_DONE;
        end else if (wc > CW'(DEPTH)) begin
            tgt = ST_ERR;
        end else begin
            tgt = ST_RECV;
        end
        return tgt;
    endfunction

    // rx_ready is registered and only high in RECV, so this is the RECV handshake.
    assign accept = bus.rx_valid && bus.rx_ready;

    // Next-state decision.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_nxt = start_target(word_count);
                end else begin
                    state_nxt = state;
                end
            end
            ST_RECV: begin
                if (accept && (byte_cnt == 2'd3)) begin
                    state_nxt = ST_WRITE;
                end else begin
                    state_nxt = ST_RECV;
                end
            end
            ST_WRITE: begin
                // word_idx never exceeds DEPTH-1, so the +1 cannot overflow CW bits
                if ((word_idx + {{(CW-1){1'b0}}, 1'b1}) == cnt) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_RECV;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; outputs follow the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            cnt            <= {CW{1'b0}};
            word_idx       <= {CW{1'b0}};
            byte_cnt       <= 2'd0;
            byte_buf       <= 24'd0;
            bus.rx_ready   <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_waddr <= 32'd0;
            bus.imem_wdata <= 32'd0;
            core_reset     <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            state          <= state_nxt;
            bus.rx_ready   <= (state_nxt == ST_RECV);
            bus.imem_we    <= (state_nxt == ST_WRITE);
            busy           <= (state_nxt == ST_RECV) || (state_nxt == ST_WRITE);
            done           <= (state_nxt == ST_DONE);
            err            <= (state_nxt == ST_ERR);
            core_reset     <= (state_nxt != ST_DONE);

            // New load: latch the count and restart both counters.
            if ((state_nxt == ST_RECV) &&
                ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR))) begin
                cnt      <= word_count;
                word_idx <= {CW{1'b0}};
                byte_cnt <= 2'd0;
            end

            if ((state == ST_RECV) && accept) begin
                byte_cnt <= byte_cnt + 2'd1;
                case (byte_cnt)
                    2'd0: byte_buf[7:0]   <= bus.rx_data;
                    2'd1: byte_buf[15:8]  <= bus.rx_data;
                    2'd2: byte_buf[23:16] <= bus.rx_data;
                    2'd3: begin
                        // Word and address are loaded together for the WRITE cycle.
                        bus.imem_wdata <= {bus.rx_data, byte_buf};
                        bus.imem_waddr <= {{(30-AW){1'b0}}, word_idx[AW-1:0], 2'b00};
                    end
                    default: byte_buf <= byte_buf;
                endcase
            end

            if (state == ST_WRITE) begin
                word_idx <= word_idx + {{(CW-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule
